pc_ctrl: RTL

//  Control-flow sequencer that drives the PC block's pc_op/target_addr interface.

---
 rtl/pc_ctrl.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/pc_ctrl.sv
// Control-flow sequencer: decodes JAL/JALR/BRANCH, issues one pc_op per instruction,
// writes the jump link and holds flush after redirects. PC_CTRL_STATS_EN adds taken/branch counters.
module pc_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int XLEN         = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [XLEN-1:0] pc_cur,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            ops_valid,
    output logic [1:0]      pc_op,
    output logic [XLEN-1:0] target_addr,
    output logic            link_we,
    output logic [4:0]      link_rd,
    output logic [XLEN-1:0] link_data,
    output logic            flush,
    output logic            illegal,
    output logic [31:0]     taken_cnt,
    output logic [31:0]     branch_cnt
);

    typedef enum logic [1:0] {IDLE, WAIT_OPS, ISSUE, FLUSH} state_t;

    localparam logic [1:0] PC_INC  = 2'b00;
    localparam logic [1:0] PC_ABS  = 2'b01;
    localparam logic [1:0] PC_REL  = 2'b10;
    localparam logic [1:0] PC_HOLD = 2'b11;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_t          state, next_state;
    logic [31:0]     instr_q;
    logic [1:0]      op_q;
    logic [XLEN-1:0] target_q;
    logic            link_q;
    logic            illegal_q;
    logic            redirect_q;
    logic [4:0]      link_rd_q;
    logic [XLEN-1:0] link_data_q;
    logic [CW-1:0]   flush_cnt;

    logic [31:0]     dec_instr;
    logic [1:0]      dec_op;
    logic [XLEN-1:0] dec_target;
    logic            dec_link;
    logic            dec_illegal;
    logic            dec_redirect;
    logic            br_taken;
    logic [XLEN-1:0] i_imm, b_imm, j_imm, jalr_sum;
    logic            needs_ops;
    logic            accept;
    logic            load_issue;

    // JAL needs no operands, so it decodes straight from the bus; JALR/BRANCH decode from the held copy.
    assign dec_instr  = (state == IDLE) ? instr : instr_q;
    assign i_imm      = {{(XLEN-12){dec_instr[31]}}, dec_instr[31:20]};
    assign b_imm      = {{(XLEN-12){dec_instr[31]}}, dec_instr[7], dec_instr[30:25], dec_instr[11:8], 1'b0};
    assign j_imm      = {{(XLEN-20){dec_instr[31]}}, dec_instr[19:12], dec_instr[20], dec_instr[30:21], 1'b0};
    assign jalr_sum   = rs1_data + i_imm;
    assign needs_ops  = (instr[6:0] == OP_JALR) || (instr[6:0] == OP_BRANCH);
    assign accept     = (state == IDLE) && instr_valid;
    assign load_issue = (accept && !needs_ops) || ((state == WAIT_OPS) && ops_valid);

    always_comb begin
        dec_op       = PC_INC;
        dec_target   = '0;
        dec_link     = 1'b0;
        dec_illegal  = 1'b0;
        dec_redirect = 1'b0;
        br_taken     = 1'b0;
        case (dec_instr[6:0])
            OP_JAL: begin
                dec_op       = PC_REL;
                dec_target   = j_imm;
                dec_link     = (dec_instr[11:7] != 5'd0);
                dec_redirect = 1'b1;
            end
            OP_JALR: begin
                dec_op       = PC_ABS;
                dec_target   = {jalr_sum[XLEN-1:1], 1'b0};
                dec_link     = (dec_instr[11:7] != 5'd0);
                dec_redirect = 1'b1;
            end
            OP_BRANCH: begin
                case (dec_instr[14:12])
                    3'b000:  br_taken = (rs1_data == rs2_data);
                    3'b001:  br_taken = (rs1_data != rs2_data);
                    3'b100:  br_taken = ($signed(rs1_data) <  $signed(rs2_data));
                    3'b101:  br_taken = ($signed(rs1_data) >= $signed(rs2_data));
                    3'b110:  br_taken = (rs1_data <  rs2_data);
                    3'b111:  br_taken = (rs1_data >= rs2_data);
                    default: dec_illegal = 1'b1;
                endcase
                if (br_taken) begin
                    dec_op       = PC_REL;
                    dec_target   = b_imm;
                    dec_redirect = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (instr_valid) begin
                    next_state = needs_ops ? WAIT_OPS : ISSUE;
                end
            end
            WAIT_OPS: begin
                if (ops_valid) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                next_state = (redirect_q && (FLUSH_CYCLES > 0)) ? FLUSH : IDLE;
            end
            FLUSH: begin
                if (flush_cnt == CW'(FLUSH_CYCLES - 1)) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // pc_op is forced to hold outside ISSUE so the PC moves exactly once per instruction.
    always_comb begin
        instr_ready = (state == IDLE);
        pc_op       = (state == ISSUE) ? op_q : PC_HOLD;
        link_we     = (state == ISSUE) && link_q;
        illegal     = (state == ISSUE) && illegal_q;
        flush       = (state == FLUSH);
    end

    assign target_addr = target_q;
    assign link_rd     = link_rd_q;
    assign link_data   = link_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q     <= '0;
            op_q        <= PC_HOLD;
            target_q    <= '0;
            link_q      <= 1'b0;
            illegal_q   <= 1'b0;
            redirect_q  <= 1'b0;
            link_rd_q   <= '0;
            link_data_q <= '0;
        end else begin
            if (accept) begin
                instr_q     <= instr;
                link_rd_q   <= instr[11:7];
                link_data_q <= pc_cur + XLEN'(4);
            end
            if (load_issue) begin
                op_q       <= dec_op;
                target_q   <= dec_target;
                link_q     <= dec_link;
                illegal_q  <= dec_illegal;
                redirect_q <= dec_redirect;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt <= '0;
        end else if (state == FLUSH) begin
            flush_cnt <= flush_cnt + CW'(1);
        end else begin
            flush_cnt <= '0;
        end
    end

`ifdef PC_CTRL_STATS_EN
    logic [31:0] taken_cnt_q, branch_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taken_cnt_q  <= '0;
            branch_cnt_q <= '0;
        end else if (state == ISSUE) begin
            if (redirect_q) begin
                taken_cnt_q <= taken_cnt_q + 32'd1;
            end
            if (instr_q[6:0] == OP_BRANCH) begin
                branch_cnt_q <= branch_cnt_q + 32'd1;
            end
        end
    end

    assign taken_cnt  = taken_cnt_q;
    assign branch_cnt = branch_cnt_q;
`else
    assign taken_cnt  = '0;
    assign branch_cnt = '0;
`endif

endmodule
